store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Store-side counterpart to the load size/extend path in the OTTER multicycle CPU.
- Takes a store request (byte address, register data, size) from the control FSM and drives the data-memory write port: word-aligned address, lane-shifted write data and 4-bit byte enables.
- Stores that straddle a word boundary are split into two sequential memory beats under a small FSM.
- Handshakes with the core on one side (valid/ready, done pulse) and with memory on the other (valid/ready).

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, memory word width; fixed at 32 (4 byte lanes), other values unsupported

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  store request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_addr  input  32  byte address
- req_data  input  32  store data, right-justified (rs2)
- req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
- done  output  1  one-cycle pulse: store fully written
- err  output  1  one-cycle pulse: misaligned store rejected (only without STORE_SPLIT_EN)
- mem_valid  output  1  write beat presented
- mem_ready  input  1  memory accepts beat when mem_valid & mem_ready
- mem_addr  output  32  word-aligned address, bits [1:0] = 00
- mem_wdata  output  32  lane-aligned write data
- mem_be  output  4  byte enables, bit i = lane i = bits [8i+7:8i]

Behaviour:
- Reset (async, any state): state=IDLE; req_ready=1 after reset deasserts; done=0, err=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0. A beat in flight is abandoned with no retry.
- Lane math, latched on accept: off=addr[1:0]; base_be=0001/0011/1111 by size; masked = data truncated to size, zero-filled above.
  - be64 = {4'b0,base_be} << off; d64 = {32'b0,masked} << (8*off)
  - beat0: addr={addr[31:2],2'b00}, wdata=d64[31:0], be=be64[3:0]
  - split = |be64[7:4]. Cases: half at off 3; word at off 1/2/3.
  - beat1: addr = beat0 addr + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); wdata=d64[63:32]; be=be64[7:4]
- FSM states: IDLE, BEAT0, BEAT1.
  - IDLE: req_ready=1; req_valid latches request and goes to BEAT0.
  - BEAT0: mem_valid=1, outputs stable until mem_ready. On handshake, go to BEAT1 if split, else IDLE with done=1 the next cycle.
  - BEAT1: mem_valid=1 until mem_ready. On handshake, go to IDLE with done=1 the next cycle.
- Latency: unsplit store takes minimum 2 cycles accept-to-done; split store takes minimum 3. Each mem_ready stall cycle adds one cycle.
- A new request may be accepted in the same cycle done is high, since the unit is in IDLE then.
- mem_addr/wdata/be are registered and hold their last values when mem_valid=0.
- req_* is sampled only on accept; changes afterwards are ignored.

Optional Feature:
- Macro: STORE_SPLIT_EN
- Defined: split behaviour as above.
- Undefined: a request with split=1 makes no memory access. The FSM stays in IDLE, err pulses one cycle after accept, and done stays 0. BEAT1 logic is not synthesized. Aligned stores are unchanged.

Decomposition:
- Shared package otter_mem_pkg:
  - size enum (BYTE=2'b00, HALF=2'b01, WORD=2'b10), the same encoding used by the load extend path
  - FSM state enum
  - lane count constant (4)
- Sub-module store_align: combinational. Takes addr[1:0], size and data; produces be64, d64 and split. It is reusable by a future AMO/cache write path.

Test Plan:
- SB addr 0x1003, data 0xDEADBEEF, mem_ready=1 -> one beat: mem_addr 0x1000, be 1000, wdata 0xEF000000; done 2 cycles after accept.
- SH addr 0x2001, data 0x1234ABCD -> one beat: addr 0x2000, be 0110, wdata 0x00ABCD00.
- SW addr 0x3002, data 0xAABBCCDD -> beat0: addr 0x3000, be 1100, wdata 0xCCDD0000; beat1: addr 0x3004, be 0011, wdata 0x0000AABB; done once. Without STORE_SPLIT_EN: no mem_valid, err pulse.
- SH addr 0xFFFFFFFF -> beat0: addr 0xFFFFFFFC, be 1000; beat1: addr 0x00000000, be 0001 (wrap).
- SW aligned with mem_ready low for 3 cycles -> mem_valid/addr/wdata/be held stable; done exactly 1 cycle after the handshake; back-to-back request accepted on the done cycle.
- rst asserted during BEAT1 stall -> all outputs 0 immediately; after release req_ready=1, and no done or second beat ever appears.

Source files
------------

// File: rtl/otter_mem_pkg.sv
// rtl/otter_mem_pkg.sv - shared memory-path types: access size, store FSM state, lane count
package otter_mem_pkg;

    localparam int LANES = 4;

    // Same encoding as the load extend path; 2'b11 is handled as a word.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10
    } store_state_e;

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - byte-lane placement of store data across a two-word window
module store_align
    import otter_mem_pkg::*;
(
    input  logic [1:0]           off_i,
    input  logic [1:0]           size_i,
    input  logic [31:0]          data_i,
    output logic [2*LANES-1:0]   be64_o,
    output logic [63:0]          d64_o,
    output logic                 split_o
);

    logic [LANES-1:0] base_be;
    logic [31:0]      masked;

    // Truncate the register data to the access size and pick its base lane mask
    always_comb begin
        base_be = 4'b1111;
        masked  = data_i;
        case (size_i)
            SZ_BYTE: begin
                base_be = 4'b0001;
                masked  = {24'b0, data_i[7:0]};
            end
            SZ_HALF: begin
                base_be = 4'b0011;
                masked  = {16'b0, data_i[15:0]};
            end
            default: begin
                base_be = 4'b1111;
                masked  = data_i;
            end
        endcase
    end

    assign be64_o  = {4'b0000, base_be} << off_i;
    assign d64_o   = {32'b0, masked} << {off_i, 3'b000};
    assign split_o = |be64_o[7:4];

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - store request to data-memory write port, splitting misaligned stores (STORE_SPLIT_EN)
module store_unit
    import otter_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [LANES-1:0]  mem_be
);

    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    store_state_e       state_q;
    logic               done_q;
    logic               err_q;
    logic               mem_valid_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [LANES-1:0]   mem_be_q;

    logic [2*LANES-1:0] be64;
    logic [63:0]        d64;
    logic               split;
    logic [ADDR_W-1:0]  base_addr;

    store_align u_align (
        .off_i   (req_addr[1:0]),
        .size_i  (req_size),
        .data_i  (req_data),
        .be64_o  (be64),
        .d64_o   (d64),
        .split_o (split)
    );

    assign base_addr = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef STORE_SPLIT_EN
    // Second beat is computed at accept time so later req_* changes cannot leak in.
    logic [ADDR_W-1:0]  hi_addr_q;
    logic [DATA_W-1:0]  hi_wdata_q;
    logic [LANES-1:0]   hi_be_q;
    logic               split_q;
`else
    logic               unused_hi;
    assign unused_hi = ^{d64[63:32], be64[7:4]};
`endif

    // Store FSM: accept in IDLE, present one or two beats, pulse done or err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
`ifdef STORE_SPLIT_EN
            hi_addr_q   <= '0;
            hi_wdata_q  <= '0;
            hi_be_q     <= '0;
            split_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
`ifndef STORE_SPLIT_EN
                        if (split) begin
                            err_q <= 1'b1;
                        end else
`endif
                        begin
                            state_q     <= ST_BEAT0;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= base_addr;
                            mem_wdata_q <= d64[31:0];
                            mem_be_q    <= be64[3:0];
`ifdef STORE_SPLIT_EN
                            hi_addr_q   <= base_addr + WORD_STEP;
                            hi_wdata_q  <= d64[63:32];
                            hi_be_q     <= be64[7:4];
                            split_q     <= split;
`endif
                        end
                    end
                end
                ST_BEAT0: begin
                    if (mem_ready) begin
`ifdef STORE_SPLIT_EN
                        if (split_q) begin
                            state_q     <= ST_BEAT1;
                            mem_addr_q  <= hi_addr_q;
                            mem_wdata_q <= hi_wdata_q;
                            mem_be_q    <= hi_be_q;
                        end else
`endif
                        begin
                            state_q     <= ST_IDLE;
                            mem_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
`ifdef STORE_SPLIT_EN
                ST_BEAT1: begin
                    if (mem_ready) begin
                        state_q     <= ST_IDLE;
                        mem_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q     <= ST_IDLE;
                    mem_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - directed self-checking bench for store_unit (both STORE_SPLIT_EN builds)
module tb_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        done;
    logic        err;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    int n_checks;
    int n_pass;

    store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .done      (done),
        .err       (err),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a request at a negedge, let it be accepted, then scramble req_*
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        chk("req_ready_at_issue", req_ready, 1);
        step();
        req_valid = 1'b0;
        req_addr  = 32'hA5A5A5A7;
        req_data  = 32'hFFFFFFFF;
        req_size  = 2'b00;
    endtask

    task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        chk({tag, "_valid"}, mem_valid, 1);
        chk({tag, "_addr"},  mem_addr,  a);
        chk({tag, "_be"},    mem_be,    be);
        chk({tag, "_wdata"}, mem_wdata, wd);
        chk({tag, "_done"},  done,      0);
    endtask

    task automatic expect_err(input string tag);
        chk({tag, "_err"},   err,       1);
        chk({tag, "_valid"}, mem_valid, 0);
        chk({tag, "_done"},  done,      0);
        step();
        chk({tag, "_err_pulse"}, err,  0);
        chk({tag, "_no_done"},   done, 0);
        chk({tag, "_no_valid"},  mem_valid, 0);
    endtask

    initial begin
        int done_seen;
        int valid_seen;
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = '0;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", mem_valid, 0);
        chk("rst_addr",  mem_addr,  0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be",    mem_be,    0);
        chk("rst_done",  done,      0);
        chk("rst_err",   err,       0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);

        // SB 0x1003: lane 3 only
        issue(32'h00001003, 32'hDEADBEEF, 2'b00);
        beat("sb", 32'h00001000, 4'b1000, 32'hEF000000);
        chk("sb_busy", req_ready, 0);
        step();
        chk("sb_done", done, 1);
        chk("sb_idle_valid", mem_valid, 0);
        chk("sb_hold_addr", mem_addr, 32'h00001000);
        step();
        chk("sb_done_pulse", done, 0);

        // SH 0x2001: lanes 1-2
        issue(32'h00002001, 32'h1234ABCD, 2'b01);
        beat("sh", 32'h00002000, 4'b0110, 32'h00ABCD00);
        step();
        chk("sh_done", done, 1);
        step();

        // SW 0x3002: straddles a word
        issue(32'h00003002, 32'hAABBCCDD, 2'b10);
`ifdef STORE_SPLIT_EN
        beat("sw_b0", 32'h00003000, 4'b1100, 32'hCCDD0000);
        step();
        beat("sw_b1", 32'h00003004, 4'b0011, 32'h0000AABB);
        step();
        chk("sw_done", done, 1);
        chk("sw_err", err, 0);
        step();
        chk("sw_done_once", done, 0);
`else
        expect_err("sw_split");
`endif

        // SH at the top of the address space wraps the second beat to 0
        issue(32'hFFFFFFFF, 32'h00005A5A, 2'b01);
`ifdef STORE_SPLIT_EN
        beat("wrap_b0", 32'hFFFFFFFC, 4'b1000, 32'h5A000000);
        step();
        beat("wrap_b1", 32'h00000000, 4'b0001, 32'h0000005A);
        step();
        chk("wrap_done", done, 1);
        step();
`else
        expect_err("wrap_split");
`endif

        // Aligned SW stalled by memory, then back-to-back accept on done
        mem_ready = 1'b0;
        issue(32'h00004000, 32'h11223344, 2'b11);
        for (int i = 0; i < 3; i++) begin
            beat("stall", 32'h00004000, 4'b1111, 32'h11223344);
            step();
        end
        beat("stall_last", 32'h00004000, 4'b1111, 32'h11223344);
        mem_ready = 1'b1;
        step();
        chk("stall_done", done, 1);
        chk("stall_valid_drop", mem_valid, 0);
        issue(32'h00005001, 32'h00000077, 2'b00);
        beat("b2b", 32'h00005000, 4'b0010, 32'h00007700);
        step();
        chk("b2b_done", done, 1);
        step();

        // Reset while a beat is stalled: abandoned, no done, no further beat
`ifdef STORE_SPLIT_EN
        issue(32'h00006001, 32'h01020304, 2'b10);
        beat("rb_b0", 32'h00006000, 4'b1110, 32'h02030400);
        mem_ready = 1'b0;
        step();
        beat("rb_b1", 32'h00006004, 4'b0001, 32'h00000001);
`else
        mem_ready = 1'b0;
        issue(32'h00006000, 32'h01020304, 2'b10);
        beat("rb_b0", 32'h00006000, 4'b1111, 32'h01020304);
`endif
        rst = 1'b1;
        #1;
        chk("rb_valid", mem_valid, 0);
        chk("rb_addr",  mem_addr,  0);
        chk("rb_wdata", mem_wdata, 0);
        chk("rb_be",    mem_be,    0);
        chk("rb_done",  done,      0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rb_ready", req_ready, 1);
        done_seen  = 0;
        valid_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) done_seen++;
            if (mem_valid) valid_seen++;
            step();
        end
        chk("rb_no_done", done_seen, 0);
        chk("rb_no_beat", valid_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
